// File: rtl/conv_index_datapath_pkg.sv
// Shared constants and types for the convolution index/address datapath.
package conv_index_datapath_pkg;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DIM_W  = 8;
    localparam int unsigned KSIZE  = 3;
    localparam logic [DATA_W-1:0] END_MARKER = 16'h00FF;

    typedef enum logic {
        WM_HOLD,
        WM_ADVANCE
    } wmem_state_e;
endpackage

// File: rtl/conv_index_datapath_if.sv
// Controller <-> datapath strobes plus the addresses/flags returned to the controller.
interface conv_index_datapath_if;
    import conv_index_datapath_pkg::*;

    logic [DATA_W-1:0] sram_dut_read_data;
    logic              str_input_nrows;
    logic              str_input_ncols;
    logic              incr_raddr_enable;
    logic              rst_dut_wmem_read_address;
    logic              incr_col_enable;
    logic              rst_col_counter;
    logic              incr_row_enable;
    logic              rst_row_counter;
    logic              incr_output_addr;
    logic              incr_waddr_enable;
    logic              dut_busy_toggle;

    logic [ADDR_W-1:0] dut_sram_read_address;
    logic [ADDR_W-1:0] dut_wmem_read_address;
    logic [ADDR_W-1:0] dut_sram_write_address;
    logic [DIM_W-1:0]  cidx;
    logic [DIM_W-1:0]  ridx;
    logic              last_col_next;
    logic              last_row_flag;
    logic              end_condition_met;
    logic              dut_busy;

    modport master (
        output sram_dut_read_data, str_input_nrows, str_input_ncols, incr_raddr_enable,
               rst_dut_wmem_read_address, incr_col_enable, rst_col_counter,
               incr_row_enable, rst_row_counter, incr_output_addr, incr_waddr_enable,
               dut_busy_toggle,
        input  dut_sram_read_address, dut_wmem_read_address, dut_sram_write_address,
               cidx, ridx, last_col_next, last_row_flag, end_condition_met, dut_busy
    );

    modport slave (
        input  sram_dut_read_data, str_input_nrows, str_input_ncols, incr_raddr_enable,
               rst_dut_wmem_read_address, incr_col_enable, rst_col_counter,
               incr_row_enable, rst_row_counter, incr_output_addr, incr_waddr_enable,
               dut_busy_toggle,
        output dut_sram_read_address, dut_wmem_read_address, dut_sram_write_address,
               cidx, ridx, last_col_next, last_row_flag, end_condition_met, dut_busy
    );
endinterface

// File: rtl/conv_index_datapath_updown_counter.sv
// Wrapping counter with synchronous clear taking priority over increment.
module conv_updown_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_incr,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_incr) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/conv_index_datapath.sv
// Index/address datapath for the convolution controller: dimension capture,
// SRAM/WMEM address generation, row/col indices, end detection and busy flag.
module conv_index_datapath
    import conv_index_datapath_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_b,
    conv_index_datapath_if.slave bus
);
    localparam logic [DIM_W:0]    KSIZE_EXT = (DIM_W + 1)'(KSIZE);
    localparam logic [ADDR_W-1:0] WMEM_DATA = {{(ADDR_W - 1){1'b0}}, 1'b1};

    logic [DIM_W-1:0]  r_nrows;
    logic [DIM_W-1:0]  r_ncols;
    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W-1:0] r_wmem_addr;
    logic              r_end;
    logic              r_busy;
    wmem_state_e       r_wm_state;

    wmem_state_e       w_wm_state_nxt;
    logic [ADDR_W-1:0] w_wmem_addr_nxt;
    logic [ADDR_W-1:0] w_raddr;
    logic [DIM_W-1:0]  w_cidx;
    logic [DIM_W-1:0]  w_ridx;
    logic [1:0]        w_wstep;
    logic              w_end_hit;
    logic [DIM_W:0]    w_cidx_ext;
    logic [DIM_W:0]    w_ridx_ext;
    logic [DIM_W:0]    w_ncols_ext;
    logic [DIM_W:0]    w_nrows_ext;

    conv_updown_counter #(.WIDTH(DIM_W)) u_col_cnt (
        .i_clk   (clk),
        .i_rst_n (reset_b),
        .i_clr   (bus.rst_col_counter),
        .i_incr  (bus.incr_col_enable),
        .o_count (w_cidx)
    );

    conv_updown_counter #(.WIDTH(DIM_W)) u_row_cnt (
        .i_clk   (clk),
        .i_rst_n (reset_b),
        .i_clr   (bus.rst_row_counter),
        .i_incr  (bus.incr_row_enable),
        .o_count (w_ridx)
    );

    // Images are packed back to back, so the read address is never cleared.
    conv_updown_counter #(.WIDTH(ADDR_W)) u_raddr_cnt (
        .i_clk   (clk),
        .i_rst_n (reset_b),
        .i_clr   (1'b0),
        .i_incr  (bus.incr_raddr_enable),
        .o_count (w_raddr)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_nrows <= '0;
            r_ncols <= '0;
        end else begin
            if (bus.str_input_nrows) r_nrows <= bus.sram_dut_read_data[DIM_W-1:0];
            if (bus.str_input_ncols) r_ncols <= bus.sram_dut_read_data[DIM_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_wm_state  <= WM_HOLD;
            r_wmem_addr <= '0;
        end else begin
            r_wm_state  <= w_wm_state_nxt;
            r_wmem_addr <= w_wmem_addr_nxt;
        end
    end

    // Restart points at the dims word, then steps once onto the data word.
    always_comb begin
        w_wm_state_nxt  = r_wm_state;
        w_wmem_addr_nxt = r_wmem_addr;
        if (bus.rst_dut_wmem_read_address) begin
            w_wm_state_nxt  = WM_ADVANCE;
            w_wmem_addr_nxt = '0;
        end else begin
            case (r_wm_state)
                WM_ADVANCE: begin
                    w_wm_state_nxt  = WM_HOLD;
                    w_wmem_addr_nxt = WMEM_DATA;
                end
                default: ;
            endcase
        end
    end

    assign w_wstep = {1'b0, bus.incr_output_addr} + {1'b0, bus.incr_waddr_enable};

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_waddr <= '0;
        end else begin
            r_waddr <= r_waddr + ADDR_W'(w_wstep);
        end
    end

    assign w_end_hit = bus.str_input_nrows && (bus.sram_dut_read_data == END_MARKER);

    // End detection forces busy low and overrides a coincident toggle;
    // a busy 0->1 transition starts a new run and clears the sticky end flag.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_end  <= 1'b0;
            r_busy <= 1'b0;
        end else if (w_end_hit) begin
            r_end  <= 1'b1;
            r_busy <= 1'b0;
        end else if (bus.dut_busy_toggle) begin
            r_busy <= ~r_busy;
            if (!r_busy) r_end <= 1'b0;
        end
    end

    assign w_cidx_ext  = {1'b0, w_cidx};
    assign w_ridx_ext  = {1'b0, w_ridx};
    assign w_ncols_ext = {1'b0, r_ncols};
    assign w_nrows_ext = {1'b0, r_nrows};

    // nrows==0 means no dimensions captured yet; keep the flag low so reset leaves all outputs 0.
    assign bus.last_col_next = (w_ncols_ext >= KSIZE_EXT) && (w_cidx_ext == (w_ncols_ext - KSIZE_EXT));
    assign bus.last_row_flag = (r_nrows != '0) && ((w_ridx_ext + KSIZE_EXT) >= w_nrows_ext);

    assign bus.dut_sram_read_address  = w_raddr;
    assign bus.dut_wmem_read_address  = r_wmem_addr;
    assign bus.dut_sram_write_address = r_waddr;
    assign bus.cidx                   = w_cidx;
    assign bus.ridx                   = w_ridx;
    assign bus.end_condition_met      = r_end;
    assign bus.dut_busy               = r_busy;
endmodule

// File: tb/tb_conv_index_datapath.sv
// Self-checking bench for conv_index_datapath: directed vector table, corner sequences, random vs model.
module tb_conv_index_datapath;
    import conv_index_datapath_pkg::*;

    localparam logic [10:0] S_NR   = 11'h001;
    localparam logic [10:0] S_NC   = 11'h002;
    localparam logic [10:0] S_IRA  = 11'h004;
    localparam logic [10:0] S_RWM  = 11'h008;
    localparam logic [10:0] S_ICOL = 11'h010;
    localparam logic [10:0] S_RCOL = 11'h020;
    localparam logic [10:0] S_IROW = 11'h040;
    localparam logic [10:0] S_RROW = 11'h080;
    localparam logic [10:0] S_IOUT = 11'h100;
    localparam logic [10:0] S_IWAD = 11'h200;
    localparam logic [10:0] S_BTOG = 11'h400;
    localparam int NVEC = 17;

    typedef struct {
        logic [10:0] strb;
        logic [15:0] data;
        logic [11:0] raddr, wmem, waddr;
        logic [7:0]  cidx, ridx;
        logic        lcn, lrf, endc, busy;
    } vec_t;

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state
    int unsigned m_raddr, m_waddr, m_cidx, m_ridx, m_nrows, m_ncols, m_wm_age;
    bit m_wm_seen, m_end, m_busy;

    always #5 clk = ~clk;

    conv_index_datapath_if bus();

    conv_index_datapath dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus)
    );

    task automatic drive(input logic [10:0] s, input logic [15:0] d);
        bus.str_input_nrows           = s[0];
        bus.str_input_ncols           = s[1];
        bus.incr_raddr_enable         = s[2];
        bus.rst_dut_wmem_read_address = s[3];
        bus.incr_col_enable           = s[4];
        bus.rst_col_counter           = s[5];
        bus.incr_row_enable           = s[6];
        bus.rst_row_counter           = s[7];
        bus.incr_output_addr          = s[8];
        bus.incr_waddr_enable         = s[9];
        bus.dut_busy_toggle           = s[10];
        bus.sram_dut_read_data        = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] snap();
        return {8'h00, bus.dut_sram_read_address, bus.dut_wmem_read_address,
                bus.dut_sram_write_address, bus.cidx, bus.ridx, bus.last_col_next,
                bus.last_row_flag, bus.end_condition_met, bus.dut_busy};
    endfunction

    function automatic logic [63:0] pack_exp(input logic [11:0] raddr, input logic [11:0] wmem,
                                             input logic [11:0] waddr, input logic [7:0] cidx,
                                             input logic [7:0] ridx, input logic lcn, input logic lrf,
                                             input logic endc, input logic busy);
        return {8'h00, raddr, wmem, waddr, cidx, ridx, lcn, lrf, endc, busy};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_raddr = 0; m_waddr = 0; m_cidx = 0; m_ridx = 0;
        m_nrows = 0; m_ncols = 0; m_wm_age = 0;
        m_wm_seen = 0; m_end = 0; m_busy = 0;
    endtask

    task automatic model_step(input logic [10:0] s, input logic [15:0] d);
        bit hit;
        hit = s[0] && (d == 16'h00FF);
        if (s[0]) m_nrows = d % 256;
        if (s[1]) m_ncols = d % 256;
        m_raddr = (m_raddr + s[2]) % 4096;
        if (s[3]) begin
            m_wm_seen = 1;
            m_wm_age  = 0;
        end else if (m_wm_age < 1000) begin
            m_wm_age++;
        end
        m_cidx  = s[5] ? 0 : (s[4] ? (m_cidx + 1) % 256 : m_cidx);
        m_ridx  = s[7] ? 0 : (s[6] ? (m_ridx + 1) % 256 : m_ridx);
        m_waddr = (m_waddr + s[8] + s[9]) % 4096;
        if (hit) begin
            m_end  = 1;
            m_busy = 0;
        end else if (s[10]) begin
            if (!m_busy) m_end = 0;
            m_busy = !m_busy;
        end
    endtask

    function automatic logic [63:0] model_exp();
        logic lcn, lrf;
        logic [11:0] wm;
        lcn = (m_ncols >= 3) && (m_cidx + 3 == m_ncols);
        lrf = (m_nrows != 0) && (m_ridx + 3 >= m_nrows);
        wm  = (m_wm_seen && m_wm_age >= 1) ? 12'd1 : 12'd0;
        return pack_exp(12'(m_raddr), wm, 12'(m_waddr), 8'(m_cidx), 8'(m_ridx),
                        lcn, lrf, m_end, m_busy);
    endfunction

    initial begin
        vec_t tbl[NVEC];
        int pct[11] = '{12, 12, 40, 12, 35, 10, 30, 10, 25, 25, 12};
        logic [10:0] s;
        logic [15:0] d;

        //            strb             data      raddr  wmem   waddr  cidx ridx lcn  lrf  end  busy
        tbl[0]  = '{S_NR,             16'h0005, 12'h0, 12'h0, 12'h0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{S_NC,             16'h0006, 12'h0, 12'h0, 12'h0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{S_ICOL,           16'h0000, 12'h0, 12'h0, 12'h0, 8'd1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{S_ICOL,           16'h0000, 12'h0, 12'h0, 12'h0, 8'd2, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{S_ICOL,           16'h0000, 12'h0, 12'h0, 12'h0, 8'd3, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{S_IROW,           16'h0000, 12'h0, 12'h0, 12'h0, 8'd3, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{S_IROW,           16'h0000, 12'h0, 12'h0, 12'h0, 8'd3, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{S_ICOL,           16'h0000, 12'h0, 12'h0, 12'h0, 8'd4, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{S_ICOL | S_RCOL,  16'h0000, 12'h0, 12'h0, 12'h0, 8'd0, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{S_IRA,            16'h0000, 12'h1, 12'h0, 12'h0, 8'd0, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{S_BTOG,           16'h0000, 12'h1, 12'h0, 12'h0, 8'd0, 8'd2, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{S_IOUT | S_IWAD,  16'h0000, 12'h1, 12'h0, 12'h2, 8'd0, 8'd2, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{S_NR,             16'h01FF, 12'h1, 12'h0, 12'h2, 8'd0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{S_NR,             16'h00FF, 12'h1, 12'h0, 12'h2, 8'd0, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{S_BTOG,           16'h0000, 12'h1, 12'h0, 12'h2, 8'd0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{S_RROW,           16'h0000, 12'h1, 12'h0, 12'h2, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{S_NR | S_BTOG,    16'h00FF, 12'h1, 12'h0, 12'h2, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};

        drive('0, '0);
        reset_b = 1'b0;
        tick();
        tick();
        check("reset_state", snap(), 64'h0);
        reset_b = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].strb, tbl[i].data);
            tick();
            check($sformatf("vec%0d", i), snap(),
                  pack_exp(tbl[i].raddr, tbl[i].wmem, tbl[i].waddr, tbl[i].cidx, tbl[i].ridx,
                           tbl[i].lcn, tbl[i].lrf, tbl[i].endc, tbl[i].busy));
        end

        // Write address: dual strobe and wrap
        drive(S_IOUT, '0);
        for (int i = 0; i < 14; i++) tick();
        check("waddr_0x010", 64'(bus.dut_sram_write_address), 64'h010);
        drive(S_IOUT | S_IWAD, '0);
        tick();
        check("waddr_dual", 64'(bus.dut_sram_write_address), 64'h012);
        for (int i = 0; i < 2038; i++) tick();
        drive(S_IOUT, '0);
        tick();
        check("waddr_0xFFF", 64'(bus.dut_sram_write_address), 64'hFFF);
        tick();
        check("waddr_wrap", 64'(bus.dut_sram_write_address), 64'h000);

        // WMEM address restart sequence
        drive(S_RWM, '0);
        tick();
        check("wmem_dims", 64'(bus.dut_wmem_read_address), 64'h0);
        drive('0, '0);
        tick();
        check("wmem_data", 64'(bus.dut_wmem_read_address), 64'h1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("wmem_hold%0d", i), 64'(bus.dut_wmem_read_address), 64'h1);
        end
        drive(S_RWM, '0);
        tick();
        check("wmem_restart", 64'(bus.dut_wmem_read_address), 64'h0);
        drive('0, '0);
        tick();
        check("wmem_readvance", 64'(bus.dut_wmem_read_address), 64'h1);

        // Asynchronous reset mid-run
        reset_b = 1'b0;
        tick();
        reset_b = 1'b1;
        drive(S_IRA, '0);
        for (int i = 0; i < 18; i++) tick();
        drive(S_BTOG | S_ICOL | S_IOUT | S_NC, 16'h0004);
        tick();
        drive('0, '0);
        check("raddr_0x012", 64'(bus.dut_sram_read_address), 64'h012);
        #2;
        reset_b = 1'b0;
        #1;
        check("async_reset", snap(), 64'h0);
        tick();
        reset_b = 1'b1;

        // Random stimulus against the reference model
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 11; b++) s[b] = ($urandom_range(0, 99) < pct[b]);
            case ($urandom_range(0, 3))
                0: d = 16'h00FF;
                1: d = 16'h01FF;
                2: d = 16'($urandom_range(0, 12));
                default: d = 16'($urandom);
            endcase
            drive(s, d);
            tick();
            model_step(s, d);
            check($sformatf("rand%0d", c), snap(), model_exp());
        end

        drive('0, '0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
